// File: rtl/ladybird_boot_ctrl_pkg.sv
// ladybird_boot_ctrl_pkg: shared boot-sequencer types and limits for the ladybird SoC tops.
package ladybird_config;

    localparam int MAX_BOOT_CORES = 8;

    typedef enum logic [1:0] {BOOT_SYNC, BOOT_HOLD, BOOT_START, BOOT_RUN} boot_state_e;

    localparam logic [1:0] S_SYNC  = BOOT_SYNC;
    localparam logic [1:0] S_HOLD  = BOOT_HOLD;
    localparam logic [1:0] S_START = BOOT_START;
    localparam logic [1:0] S_RUN   = BOOT_RUN;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ladybird_boot_ctrl_if.sv
// ladybird_boot_ctrl_if: soft-reset/watchdog requests in, fabric reset and per-core boot status out.
interface ladybird_boot_ctrl_if #(parameter int N_CORES = 2);

    logic               soft_rst_req_i;
    logic               kick_i;
    logic               nrst_o;
    logic [N_CORES-1:0] core_start_o;
    logic [N_CORES-1:0] core_run_o;
    logic               boot_done_o;
    logic               wdt_fired_o;

    modport master (
        output soft_rst_req_i, kick_i,
        input  nrst_o, core_start_o, core_run_o, boot_done_o, wdt_fired_o
    );

    modport slave (
        input  soft_rst_req_i, kick_i,
        output nrst_o, core_start_o, core_run_o, boot_done_o, wdt_fired_o
    );

endinterface

// File: rtl/ladybird_boot_ctrl_reset_sync.sv
// ladybird_reset_sync: async-assert, sync-deassert reset synchroniser, reusable in any clock domain.
module ladybird_reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic anrst_i,
    output logic o_nrst
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) r_sync <= '0;
        else          r_sync <= (r_sync << 1) | STAGES'(1);
    end

    assign o_nrst = r_sync[STAGES-1];

endmodule

// File: rtl/ladybird_boot_ctrl.sv
// ladybird_boot_ctrl: reset synchroniser, fabric reset hold and staggered multi-core start sequencer.
// Optional watchdog-triggered soft reset is built when LADYBIRD_BOOT_WDT_EN is defined.
module ladybird_boot_ctrl
    import ladybird_config::*;
#(
    parameter int N_CORES        = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int WDT_CYCLES     = 1024
) (
    input  logic                 clk_i,
    input  logic                 anrst_i,
    ladybird_boot_ctrl_if.slave  bus
);

    localparam int CW = $clog2(max3(HOLD_CYCLES, STAGGER_CYCLES, WDT_CYCLES) + 1);

    if (N_CORES < 1 || N_CORES > MAX_BOOT_CORES || SYNC_STAGES < 2 ||
        HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 || WDT_CYCLES < 1) begin : g_bad_param
        $error("ladybird_boot_ctrl: illegal parameter value");
    end

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_idx;
    logic               r_nrst;
    logic               r_done;
    logic [N_CORES-1:0] r_start;
    logic [N_CORES-1:0] r_run;
    logic               w_sync;
    logic               w_wdt_exp;
    logic [CW-1:0]      w_run_cnt;
    logic [N_CORES-1:0] w_onehot;

    // The SYNC-state flop acts as the last synchroniser stage, so HOLD begins on edge SYNC_STAGES.
    ladybird_reset_sync #(.STAGES(SYNC_STAGES - 1)) u_sync (
        .clk_i   (clk_i),
        .anrst_i (anrst_i),
        .o_nrst  (w_sync)
    );

    assign w_onehot = N_CORES'(1) << r_idx;

`ifdef LADYBIRD_BOOT_WDT_EN
    logic r_wdt_fired;
    assign w_wdt_exp = (r_state == S_RUN) && !bus.kick_i && (r_cnt == CW'(WDT_CYCLES - 1));
    assign w_run_cnt = bus.kick_i ? '0 : r_cnt + 1'b1;
    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) r_wdt_fired <= 1'b0;
        else          r_wdt_fired <= r_wdt_fired | w_wdt_exp;
    end
    assign bus.wdt_fired_o = r_wdt_fired;
`else
    logic w_unused_kick;
    assign w_unused_kick   = bus.kick_i;
    assign w_wdt_exp       = 1'b0;
    assign w_run_cnt       = r_cnt;
    assign bus.wdt_fired_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) begin
            r_state <= S_SYNC;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_nrst  <= 1'b0;
            r_done  <= 1'b0;
            r_start <= '0;
            r_run   <= '0;
        end else begin
            r_start <= '0;
            if (r_state != S_SYNC && (bus.soft_rst_req_i || w_wdt_exp)) begin
                r_state <= S_HOLD;
                r_cnt   <= '0;
                r_nrst  <= 1'b0;
                r_done  <= 1'b0;
                r_run   <= '0;
            end else begin
                case (r_state)
                    S_SYNC: begin
                        if (w_sync) begin
                            r_state <= S_HOLD;
                            r_cnt   <= '0;
                        end
                    end
                    S_HOLD: begin
                        if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                            r_state <= S_START;
                            r_nrst  <= 1'b1;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_START: begin
                        if (r_run[N_CORES-1]) begin
                            r_state <= S_RUN;
                            r_done  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            if (r_cnt == '0) begin
                                r_start <= w_onehot;
                                r_run   <= r_run | w_onehot;
                                r_idx   <= r_idx + 1'b1;
                            end
                            r_cnt <= (r_cnt == CW'(STAGGER_CYCLES - 1)) ? '0 : r_cnt + 1'b1;
                        end
                    end
                    default: r_cnt <= w_run_cnt;
                endcase
            end
        end
    end

    assign bus.nrst_o       = r_nrst;
    assign bus.core_start_o = r_start;
    assign bus.core_run_o   = r_run;
    assign bus.boot_done_o  = r_done;

endmodule

// File: tb/tb_ladybird_boot_ctrl.sv
// tb_ladybird_boot_ctrl: directed timing checks of the boot sequencer in default and minimal configurations.
module tb_ladybird_boot_ctrl;

    logic clk_i = 1'b0;
    logic anrst_i = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    ladybird_boot_ctrl_if #(.N_CORES(2)) b0 ();
    ladybird_boot_ctrl_if #(.N_CORES(1)) b1 ();

    ladybird_boot_ctrl #(
        .N_CORES(2), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(4), .WDT_CYCLES(8)
    ) u0 (
        .clk_i   (clk_i),
        .anrst_i (anrst_i),
        .bus     (b0)
    );

    ladybird_boot_ctrl #(
        .N_CORES(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .WDT_CYCLES(1024)
    ) u1 (
        .clk_i   (clk_i),
        .anrst_i (anrst_i),
        .bus     (b1)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // 3 ns async reset pulse; the next rising edge is edge 1 of the new sequence
    task automatic pulse_rst();
        anrst_i = 1'b0;
        #1;
        chk("async_nrst", 32'(b0.nrst_o), 0);
        chk("async_run", 32'(b0.core_run_o), 0);
        chk("async_done", 32'(b0.boot_done_o), 0);
        #2;
        anrst_i = 1'b1;
    endtask

    initial begin
        b0.soft_rst_req_i = 1'b0;
        b0.kick_i = 1'b0;
        b1.soft_rst_req_i = 1'b0;
        b1.kick_i = 1'b0;
        #12;
        chk("rst_nrst", 32'(b0.nrst_o), 0);
        chk("rst_start", 32'(b0.core_start_o), 0);
        chk("rst_run", 32'(b0.core_run_o), 0);
        chk("rst_done", 32'(b0.boot_done_o), 0);
        chk("rst_wdt", 32'(b0.wdt_fired_o), 0);
        anrst_i = 1'b1;
        step(2);  chk("min_nrst_e2", 32'(b1.nrst_o), 0);
        step(1);  chk("min_nrst_e3", 32'(b1.nrst_o), 1);
                  chk("min_start_e3", 32'(b1.core_start_o), 0);
        step(1);  chk("min_start_e4", 32'(b1.core_start_o), 1);
                  chk("min_run_e4", 32'(b1.core_run_o), 1);
                  chk("min_done_e4", 32'(b1.boot_done_o), 0);
        step(1);  chk("min_done_e5", 32'(b1.boot_done_o), 1);
                  chk("min_start_e5", 32'(b1.core_start_o), 0);
        step(12); chk("pwr_nrst_e17", 32'(b0.nrst_o), 0);
        step(1);  chk("pwr_nrst_e18", 32'(b0.nrst_o), 1);
                  chk("pwr_start_e18", 32'(b0.core_start_o), 0);
        step(1);  chk("pwr_start_e19", 32'(b0.core_start_o), 2'b01);
                  chk("pwr_run_e19", 32'(b0.core_run_o), 2'b01);
        step(1);  chk("pwr_start_e20", 32'(b0.core_start_o), 0);
        step(3);  chk("pwr_start_e23", 32'(b0.core_start_o), 2'b10);
                  chk("pwr_run_e23", 32'(b0.core_run_o), 2'b11);
                  chk("pwr_done_e23", 32'(b0.boot_done_o), 0);
        step(1);  chk("pwr_done_e24", 32'(b0.boot_done_o), 1);
                  chk("pwr_start_e24", 32'(b0.core_start_o), 0);
                  chk("pwr_run_e24", 32'(b0.core_run_o), 2'b11);

        pulse_rst();
        step(20); chk("sr_run_e20", 32'(b0.core_run_o), 2'b01);
        b0.soft_rst_req_i = 1'b1;
        step(1);  b0.soft_rst_req_i = 1'b0;
                  chk("sr_nrst_e21", 32'(b0.nrst_o), 0);
                  chk("sr_run_e21", 32'(b0.core_run_o), 0);
        step(15); chk("sr_nrst_e36", 32'(b0.nrst_o), 0);
        step(1);  chk("sr_nrst_e37", 32'(b0.nrst_o), 1);
        step(1);  chk("sr_start_e38", 32'(b0.core_start_o), 2'b01);
        step(4);  chk("sr_start_e42", 32'(b0.core_start_o), 2'b10);
        step(1);  chk("sr_done_e43", 32'(b0.boot_done_o), 1);

        b0.soft_rst_req_i = 1'b1;
        step(20); chk("held_nrst", 32'(b0.nrst_o), 0);
                  chk("held_run", 32'(b0.core_run_o), 0);
        b0.soft_rst_req_i = 1'b0;
        step(15); chk("held_nrst_15", 32'(b0.nrst_o), 0);
        step(1);  chk("held_nrst_16", 32'(b0.nrst_o), 1);

        pulse_rst();
        step(8);
        pulse_rst();
        b0.soft_rst_req_i = 1'b1;
        step(2);  b0.soft_rst_req_i = 1'b0;
        step(15); chk("mid_nrst_e17", 32'(b0.nrst_o), 0);
        step(1);  chk("mid_nrst_e18", 32'(b0.nrst_o), 1);
        step(4);  b0.soft_rst_req_i = 1'b1;
        step(1);  b0.soft_rst_req_i = 1'b0;
                  chk("supp_start_e23", 32'(b0.core_start_o), 0);
                  chk("supp_run_e23", 32'(b0.core_run_o), 0);
                  chk("supp_nrst_e23", 32'(b0.nrst_o), 0);

        pulse_rst();
        step(24); chk("wdt_done_e24", 32'(b0.boot_done_o), 1);
`ifdef LADYBIRD_BOOT_WDT_EN
        step(7);  chk("wdt_nrst_e31", 32'(b0.nrst_o), 1);
                  chk("wdt_fired_e31", 32'(b0.wdt_fired_o), 0);
        step(1);  chk("wdt_fired_e32", 32'(b0.wdt_fired_o), 1);
                  chk("wdt_nrst_e32", 32'(b0.nrst_o), 0);
                  chk("wdt_done_e32", 32'(b0.boot_done_o), 0);
        step(22); chk("wdt_done_e54", 32'(b0.boot_done_o), 1);
                  chk("wdt_sticky", 32'(b0.wdt_fired_o), 1);
        for (int i = 0; i < 40; i++) begin
            b0.kick_i = 1'b1;
            step(1);
            b0.kick_i = 1'b0;
            step(4);
        end
        chk("kick_done", 32'(b0.boot_done_o), 1);
        chk("kick_nrst", 32'(b0.nrst_o), 1);
        step(3);  b0.kick_i = 1'b1;
        step(1);  b0.kick_i = 1'b0;
                  chk("kick_wins_nrst", 32'(b0.nrst_o), 1);
        step(7);  chk("rewdt_nrst_7", 32'(b0.nrst_o), 1);
        step(1);  chk("rewdt_nrst_8", 32'(b0.nrst_o), 0);
`else
        for (int i = 0; i < 10000; i++) begin
            b0.kick_i = i[0];
            step(1);
        end
        b0.kick_i = 1'b0;
        chk("nowdt_done", 32'(b0.boot_done_o), 1);
        chk("nowdt_fired", 32'(b0.wdt_fired_o), 0);
        chk("nowdt_nrst", 32'(b0.nrst_o), 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ladybird_boot_ctrl.md
Name: ladybird_boot_ctrl

Overview:
- Parametrised reset and boot sequencer for multi-core ladybird SoC tops.
- Replaces the single-core pattern of "one reset flop plus a 1-cycle start flop" at top level.
- Synchronises the async reset, holds the fabric in reset for a programmable time, then releases N cores with staggered one-cycle start pulses.
- Supports a fabric-wide soft reset and, optionally, a watchdog that triggers it.

Parameters:
- N_CORES, 2: number of cores sequenced; legal range 1..8.
- SYNC_STAGES, 2: reset synchroniser depth; must be >= 2.
- HOLD_CYCLES, 16: cycles nrst_o is held low after the synchronised reset releases; must be >= 1.
- STAGGER_CYCLES, 4: cycles between start pulses of consecutive cores; must be >= 1.
- WDT_CYCLES, 1024: watchdog timeout in cycles; used only with the optional feature.

Ports:
- clk_i, input, 1: system clock.
- anrst_i, input, 1: asynchronous active-low reset.
- soft_rst_req_i, input, 1: synchronous soft-reset request, sampled each edge.
- kick_i, input, 1: watchdog kick; ignored without the optional feature.
- nrst_o, output, 1: fabric reset, active-low; asynchronous assert, synchronous deassert.
- core_start_o, output, N_CORES: per-core one-cycle start pulse.
- core_run_o, output, N_CORES: per-core level, high once that core has been started.
- boot_done_o, output, 1: high when all cores are running.
- wdt_fired_o, output, 1: sticky watchdog-expiry flag.

Behaviour:
- Reset values while anrst_i is low: nrst_o=0, core_start_o=0, core_run_o=0, boot_done_o=0, wdt_fired_o=0, FSM=SYNC. All take effect asynchronously.
- Synchroniser: SYNC_STAGES flops, async-cleared, shift in 1.
  - Edge 1 is the first rising clk_i edge with anrst_i high.
  - Synchronised reset is high after edge SYNC_STAGES.
- FSM states: SYNC, HOLD, START, RUN.
  - SYNC -> HOLD when the synchroniser output is high. Counter is loaded with 0.
  - HOLD: counter increments each cycle. Reaching HOLD_CYCLES-1 -> START, and nrst_o=1 registered on that same edge. nrst_o therefore rises after edge SYNC_STAGES+HOLD_CYCLES.
  - START: idx starts at 0. On the first START edge: core_start_o[0]=1 for one cycle, core_run_o[0]=1.
    - Then, every STAGGER_CYCLES edges: idx+1, pulse core_start_o[idx], set core_run_o[idx].
    - The edge after the pulse for idx=N_CORES-1 -> RUN, boot_done_o=1.
  - RUN: steady state. Outputs hold.
- Timing with defaults (N=2, SYNC=2, HOLD=16, STAGGER=4):
  - nrst_o high after edge 18.
  - core_start_o[0] high after edge 19.
  - core_start_o[1] high after edge 23.
  - boot_done_o high after edge 24.
- Exactly one bit of core_start_o is high in any cycle, or none.
- Soft reset:
  - soft_rst_req_i high at an edge in HOLD, START or RUN: on that edge nrst_o=0, core_start_o=0, core_run_o=0, boot_done_o=0, counter reloaded to 0, FSM=HOLD.
  - The sequence then repeats from HOLD. nrst_o rises HOLD_CYCLES edges later.
  - Ignored in SYNC.
  - A request on the same edge a start pulse would issue suppresses the pulse.
  - A request held high keeps restarting HOLD, so nrst_o stays low.
- anrst_i low mid-sequence: immediate async return to reset values. The full sequence restarts from SYNC.
- Counter width: $clog2(max(HOLD_CYCLES, STAGGER_CYCLES, WDT_CYCLES)+1). No wrap-around is reachable.

Optional Feature:
- Macro: LADYBIRD_BOOT_WDT_EN.
- Enabled:
  - In RUN, the watchdog counter increments each cycle and is cleared by kick_i=1.
  - If it reaches WDT_CYCLES-1 without a kick, then on the next edge: wdt_fired_o=1 (sticky, cleared only by anrst_i), and a soft reset is performed exactly as above.
  - Kick on the expiry edge wins: no fire.
  - The counter is cleared on leaving RUN.
- Disabled: no watchdog logic, kick_i unused, wdt_fired_o tied 0.

Decomposition:
- ladybird_config gains: boot_state_e (SYNC, HOLD, START, RUN) and localparam MAX_BOOT_CORES=8.
- Sub-module ladybird_reset_sync (parameter STAGES): async-assert, sync-deassert synchroniser. Reused for other clock domains.

Test Plan:
- Power-up with defaults: release anrst_i -> nrst_o rises after edge 18; start pulses after edges 19 and 23; boot_done_o after edge 24; core_run_o=2'b11.
- N_CORES=1, HOLD_CYCLES=1, STAGGER_CYCLES=1 -> nrst_o after edge 3, core_start_o[0] after edge 4, boot_done_o after edge 5.
- soft_rst_req_i one-cycle pulse at edge 21 (between start pulses) -> nrst_o=0 and core_run_o=0 after edge 21; nrst_o high again after edge 37; pulses after edges 38 and 42.
- anrst_i low for 3 ns mid-HOLD -> all outputs 0 immediately; full 18-edge sequence repeats.
- With LADYBIRD_BOOT_WDT_EN, WDT_CYCLES=8, no kick in RUN -> wdt_fired_o=1 and nrst_o=0 eight edges after RUN entry. With a kick every 5 cycles -> never fires.
- Without the macro: kick_i toggling and 10000 RUN cycles -> wdt_fired_o=0, boot_done_o stays 1.
